// File: rtl/seq_timing_decoder_if.sv
// Bus bundle for the timing/decode stage: control-side requests in, timing and
// decode vectors out. The master side is the controller, the slave side is the stage.
interface seq_timing_decoder_if #(
  parameter int IR_W = 16
);
  logic [IR_W-1:0] mem_data;
  logic            sc_clr;
  logic            hlt;
  logic            start;
  logic [5:0]      T;
  logic [7:0]      D;
  logic            I;
  logic [IR_W-1:0] ir_q;
  logic            running;
  logic            r_ref;
  logic            io_ref;

  // Level signals, no handshake: every input is sampled on each rising edge,
  // every output is a pure function of registered state and valid every cycle.
  modport master (
    output mem_data, sc_clr, hlt, start,
    input  T, D, I, ir_q, running, r_ref, io_ref
  );

  modport slave (
    input  mem_data, sc_clr, hlt, start,
    output T, D, I, ir_q, running, r_ref, io_ref
  );
endinterface

// File: rtl/seq_timing_decoder.sv
// Sequence counter, instruction register, run flip-flop and opcode decoder that
// produce the one-hot T and D vectors for the downstream control stages.
module seq_timing_decoder #(
  parameter int IR_W  = 16,
  parameter int NUM_T = 6
) (
  input logic                 clk,
  input logic                 rst,
  seq_timing_decoder_if.slave bus
);

  typedef enum logic {
    HALTED  = 1'b0,
    RUNNING = 1'b1
  } run_e;

  localparam logic [2:0] SC_LAST = 3'(NUM_T - 1);
  localparam logic [2:0] SC_FETCH = 3'd1;

  run_e            run_q, run_d;
  logic [2:0]      sc_q, sc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [2:0]      opcode;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= RUNNING;
      sc_q  <= '0;
      ir_q  <= '0;
    end else begin
      run_q <= run_d;
      sc_q  <= sc_d;
      ir_q  <= ir_d;
    end
  end

  always_comb begin
    run_d = run_q;
    sc_d  = sc_q + 3'd1;
    ir_d  = ir_q;

    // hlt outranks start so a simultaneous pair leaves the machine halted
    if (bus.hlt) begin
      run_d = HALTED;
    end else if (bus.start) begin
      run_d = RUNNING;
    end

    if (run_q == HALTED || bus.hlt || bus.sc_clr || sc_q == SC_LAST) begin
      sc_d = '0;
    end

    // Fetch at T1 happens even when sc_clr ends the instruction in that cycle
    if (run_q == RUNNING && sc_q == SC_FETCH) begin
      ir_d = bus.mem_data;
    end
  end

  assign opcode = ir_q[IR_W-2 -: 3];

  always_comb begin
    bus.T       = (run_q == RUNNING) ? (6'b000001 << sc_q) : 6'b000000;
    bus.D       = 8'b00000001 << opcode;
    bus.I       = ir_q[IR_W-1];
    bus.ir_q    = ir_q;
    bus.running = (run_q == RUNNING);
    bus.r_ref   = bus.D[7] & ~bus.I & bus.T[3];
    bus.io_ref  = bus.D[7] &  bus.I & bus.T[3];
  end

endmodule

// File: doc/seq_timing_decoder.md
Name: seq_timing_decoder

Overview:
- Timing and decode stage directly upstream of the PC control logic; generates the one-hot timing vector T[5:0] and the one-hot opcode vector D[7:0] that the PC, AR, AC and memory control stages consume.
- Contains a 3-bit sequence counter (SC), the 16-bit instruction register (IR), the run flip-flop (S) and the 3-to-8 opcode decoder.
- Fetch convention: the IR loads from memory data at T1, the same cycle the PC stage increments.

Parameters:
- IR_W, 16, instruction width; bit IR_W-1 is the indirect bit I, bits IR_W-2:IR_W-4 are the opcode.
- NUM_T, 6, number of timing states; fixed to match the T port width; SC counts 0..NUM_T-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_data  input  IR_W  memory read word; sampled into IR at T1.
- sc_clr  input  1  end-of-instruction request from control; forces SC to 0 next edge.
- hlt  input  1  HLT microoperation; clears S.
- start  input  1  sets S (restart after halt).
- T  output  6  one-hot timing signals T0..T5; all zero while halted.
- D  output  8  one-hot decode of IR opcode field.
- I  output  1  IR indirect bit.
- ir_q  output  IR_W  current IR contents.
- running  output  1  S flip-flop value.
- r_ref  output  1  register-reference strobe: D7 & ~I & T3.
- io_ref  output  1  I/O strobe: D7 & I & T3.

Behaviour:
- Reset (rst=1 at edge): SC=0, IR=0, S=1. First cycle after reset: T=6'b000001, D=8'b00000001, I=0, ir_q=0, running=1, r_ref=io_ref=0.
- T = one-hot(SC) gated by S; when S=0, T=0. r_ref and io_ref are therefore also 0 while halted.
- D = one-hot(IR[IR_W-2:IR_W-4]); I = IR[IR_W-1]. Both are combinational from the registered IR.
- SC update priority per edge:
  - rst: SC=0.
  - Else if S=0: SC=0 (held).
  - Else if hlt: SC=0.
  - Else if sc_clr: SC=0.
  - Else if SC=NUM_T-1: SC=0 (automatic wrap after T5).
  - Else: SC=SC+1.
- S update priority: rst sets S=1; else hlt clears S=0 (hlt beats start when both are asserted); else start sets S=1; else hold.
- Halt/restart timing:
  - hlt asserted in a cycle with T=Tk: the next cycle has running=0, T=0.
  - start asserted while halted: the next cycle has running=1, T=T0.
  - start while already running: no effect.
- IR load: IR<=mem_data on an edge where S=1 and SC=1 (T1 active) and rst=0. New D/I are visible from the T2 cycle onward. IR holds otherwise, including while halted and across sc_clr.
- sc_clr and T1 in the same cycle: IR still loads; SC goes to 0.
- sc_clr while halted: ignored.
- Reset mid-instruction: IR returns to 0 and SC to 0 regardless of state; the next cycle is T0.
- Latency:
  - SC advances 1 state per clock.
  - D becomes valid 1 cycle after the T1 load edge.
  - r_ref/io_ref are combinational with T3.
- No X on any output after the first reset edge.

Test Plan:
- Reset then free run, with sc_clr=hlt=start=0 and mem_data=16'h0000 -> T cycles 01,02,04,08,10,20,01 across 7 consecutive clocks; running=1 throughout; D=8'h01.
- mem_data=16'h4123 held at T1 -> from T2: ir_q=16'h4123, D=8'h10 (D4), I=0; at T4, D4&T4=1, so the downstream PC load fires exactly once per instruction.
- mem_data=16'hF400 at T1 -> I=1, D=8'h80; io_ref=1 only in the T3 cycle, r_ref=0. Repeat with 16'h7800 -> r_ref=1 at T3, io_ref=0.
- sc_clr pulsed during T3 -> next cycle T=01 (T4/T5 skipped); IR unchanged; with sc_clr held during T1, IR still loads.
- hlt pulsed during T2 -> next cycle running=0, T=00, and T stays 00 for 5 cycles. start then -> next cycle T=01. hlt and start together -> running stays/becomes 0.
- rst asserted during T4 with IR=16'h4123 -> next cycle T=01, ir_q=0, D=8'h01, running=1.
